ttl283_adder: RTL and testbench
===============================

// Module: ttl283_adder
// PURPOSE
//   Behavioural model of the 74LS283 4-bit binary full adder with fast (lookahead) carry.
//   Computes {C4,S} = A + B + C0 combinationally, with a modelled propagation delay.
//   Also provides a clocked snapshot of the result for synchronous datapath consumers.
//   Used as an arithmetic building block (accumulator/subtractor slices) in the TTL-level machine model.
// PARAMETERS
//   PROPAGATION_DELAY  24  ns from any A/B/C0 change to settled S/C4 (datasheet max); must be < 50
// PORTS
//   clk    in   1  clock; samples the registered outputs only
//   reset  in   1  asynchronous, active-high reset; clears the registered outputs only
//   A      in   4  operand A, bit 0 = LSB
//   B      in   4  operand B, bit 0 = LSB
//   C0     in   1  carry in to bit 0
//   S      out  4  combinational sum, bits [3:0] of A+B+C0
//   C4     out  1  combinational carry out, bit 4 of A+B+C0
//   S_Q    out  4  registered copy of the sum
//   C4_Q   out  1  registered copy of the carry out
// BEHAVIOUR
//   - Arithmetic: {C4,S} = {1'b0,A} + {1'b0,B} + C0 (5-bit, unsigned); range 0..31, no wrap beyond C4.
//   - Carry lookahead: G[i]=A[i]&B[i], P[i]=A[i]^B[i]; C[i+1]=G[i]|P[i]&C[i]
//     (flattened sum-of-products per bit); S[i]=P[i]^C[i].
//   - S/C4: purely combinational with inertial delay PROPAGATION_DELAY.
//     Pulses shorter than the delay are swallowed.
//     Fully settled within PROPAGATION_DELAY of the last input change.
//   - S/C4 are unaffected by clk and reset.
//     Before inputs are first driven, X on inputs propagates as X.
//   - S_Q/C4_Q: on posedge clk, load the undelayed internal sum/carry.
//   - reset=1: S_Q=4'h0 and C4_Q=0 immediately (asynchronous); held while reset is high.
//     The first load happens on the first posedge after deassertion.
//   - Latency: combinational path is 0 cycles (+ delay); registered path is 1 cycle.
//   - Boundaries: 15+15+1 gives C4=1, S=4'hF.
//     0+0+1 gives S=1, C4=0.
//     10+5+1 carry-ripples through all bits, giving {C4,S}=5'b10000.
// CONFIGURATION
//   TTL283_OVERFLOW_EN defined:
//     - Adds output OVF (1 bit, combinational, same delay) = C[3]^C4 (two's-complement overflow).
//     - Adds output OVF_Q (registered, reset to 0).
//   TTL283_OVERFLOW_EN undefined: neither port exists; all other behaviour is identical.
// STRUCTURE
//   Shared package ttl_pkg:
//     - localparam TTL_WIDTH_NIBBLE=4
//     - default delay constants for TTL families (LS283 = 24 ns)
//   Natural sub-module: ttl283_cla_nibble.
//     - Pure combinational G/P/lookahead carry and sum logic, with no delay.
//     - Instantiated once.
//     - The top adds the delayed output assigns and the snapshot registers.
// TESTING (check 50 ns after each stimulus; registered checks 1 clk later)
//   1. A=0,B=0,C0=0 -> {C4,S}=00000; A=5,B=3,C0=0 -> 01000
//   2. A=7,B=6,C0=1 -> 01110; A=8,B=8,C0=0 -> 10000 (carry out, S=0)
//   3. A=F,B=F,C0=0 -> 11110; A=F,B=F,C0=1 -> 11111; A=0,B=0,C0=1 -> 00001
//   4. A=9,B=4,C0=0 -> 01101; A=C,B=7,C0=1 -> 10100; A=F,B=0 / A=0,B=F, C0=0 -> 01111
//   5. A=A,B=5,C0=1 -> 10000; also sample S at PROPAGATION_DELAY-1 ns -> old value still present
//   6. Registered path:
//      - assert reset mid-run -> S_Q=0, C4_Q=0 without a clock edge
//      - release reset, set A=C,B=7,C0=1, one posedge -> S_Q=4, C4_Q=1
//      - with TTL283_OVERFLOW_EN: A=7,B=1,C0=0 -> OVF=1

Source files
------------

// File: rtl/ttl_pkg.sv
// ttl_pkg: shared constants for the TTL-level machine model.
//   TTL_WIDTH_NIBBLE : datapath width of a 4-bit TTL arithmetic slice
//   *_DELAY_NS       : default worst-case propagation delays per logic family
// Used by: ttl283_adder, ttl283_cla_nibble, ttl283_adder_if.
`timescale 1ns/1ps
package ttl_pkg;
  localparam int TTL_WIDTH_NIBBLE = 4;

  // Datasheet max input-to-output delays, in ns.
  localparam int LS283_DELAY_NS = 24;
  localparam int S283_DELAY_NS  = 18;
  localparam int F283_DELAY_NS  = 10;
endpackage

// File: rtl/ttl283_adder_if.sv
// ttl283_adder_if: operand/result bundle of the 74LS283 model.
//   A, B, C0   : operands and carry in (driven by the master)
//   S, C4      : delayed combinational sum / carry out
//   S_Q, C4_Q  : clocked snapshot of the sum / carry out
//   OVF, OVF_Q : two's-complement overflow, present only with TTL283_OVERFLOW_EN
// Modports: master (operand source / result consumer), slave (the adder).
`timescale 1ns/1ps
interface ttl283_adder_if;
  import ttl_pkg::*;

  logic [TTL_WIDTH_NIBBLE-1:0] A;
  logic [TTL_WIDTH_NIBBLE-1:0] B;
  logic                        C0;
  logic [TTL_WIDTH_NIBBLE-1:0] S;
  logic                        C4;
  logic [TTL_WIDTH_NIBBLE-1:0] S_Q;
  logic                        C4_Q;
`ifdef TTL283_OVERFLOW_EN
  logic                        OVF;
  logic                        OVF_Q;
`endif

  modport master (
    output A, B, C0,
    input  S, C4, S_Q, C4_Q
`ifdef TTL283_OVERFLOW_EN
    , input OVF, OVF_Q
`endif
  );

  modport slave (
    input  A, B, C0,
    output S, C4, S_Q, C4_Q
`ifdef TTL283_OVERFLOW_EN
    , output OVF, OVF_Q
`endif
  );
endinterface

// File: rtl/ttl283_cla_nibble.sv
// ttl283_cla_nibble: zero-delay 4-bit carry-lookahead adder core.
//   a, b  in  4 : operands
//   c0    in  1 : carry in
//   s     out 4 : sum bits
//   c3    out 1 : carry into bit 3 (used for overflow detection)
//   c4    out 1 : carry out
`timescale 1ns/1ps
module ttl283_cla_nibble
  import ttl_pkg::*;
(
  input  logic [TTL_WIDTH_NIBBLE-1:0] a,
  input  logic [TTL_WIDTH_NIBBLE-1:0] b,
  input  logic                        c0,
  output logic [TTL_WIDTH_NIBBLE-1:0] s,
  output logic                        c3,
  output logic                        c4
);
  logic [TTL_WIDTH_NIBBLE-1:0] g;
  logic [TTL_WIDTH_NIBBLE-1:0] p;
  logic                        c1;
  logic                        c2;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum of products of G/P/c0, as in the 74LS283
  // lookahead network, rather than a ripple chain.
  assign c1 = g[0] | (p[0] & c0);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & c0);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);

  assign s = p ^ {c3, c2, c1, c0};
endmodule

// File: rtl/ttl283_adder.sv
// ttl283_adder: behavioural 74LS283 4-bit binary full adder with fast carry.
//   clk    in : clocks the snapshot registers only
//   reset  in : async active-high, clears the snapshot registers only
//   bus       : ttl283_adder_if.slave (A, B, C0 in; S, C4, S_Q, C4_Q out)
// Parameter PROPAGATION_DELAY (ns, < 50): inertial delay on S/C4 (and OVF).
// Macro TTL283_OVERFLOW_EN adds OVF/OVF_Q (two's-complement overflow).
`timescale 1ns/1ps
module ttl283_adder
  import ttl_pkg::*;
#(
  parameter int PROPAGATION_DELAY = LS283_DELAY_NS
) (
  input  logic             clk,
  input  logic             reset,
  ttl283_adder_if.slave    bus
);
  logic [TTL_WIDTH_NIBBLE-1:0] sum;
  logic                        c3;
  logic                        c4;
  logic [TTL_WIDTH_NIBBLE-1:0] s_q;
  logic                        c4_q;

  ttl283_cla_nibble u_cla (
    .a  (bus.A),
    .b  (bus.B),
    .c0 (bus.C0),
    .s  (sum),
    .c3 (c3),
    .c4 (c4)
  );

  // Continuous-assign delays are inertial: input glitches shorter than
  // the delay never reach S/C4. Synthesis drops the delay.
  assign #(PROPAGATION_DELAY) bus.S  = sum;
  assign #(PROPAGATION_DELAY) bus.C4 = c4;

  // Snapshot takes the undelayed result so it is valid one cycle later
  // regardless of the modelled propagation delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q  <= '0;
      c4_q <= 1'b0;
    end else begin
      s_q  <= sum;
      c4_q <= c4;
    end
  end

  assign bus.S_Q  = s_q;
  assign bus.C4_Q = c4_q;

`ifdef TTL283_OVERFLOW_EN
  logic ovf;
  logic ovf_q;

  assign ovf = c3 ^ c4;
  assign #(PROPAGATION_DELAY) bus.OVF = ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf;
  end

  assign bus.OVF_Q = ovf_q;
`else
  // Carry into bit 3 only matters for overflow detection.
  logic unused_c3;
  assign unused_c3 = c3;
`endif
endmodule

// File: tb/tb_ttl283_adder.sv
// tb_ttl283_adder: directed-vector bench for ttl283_adder.
// Honours TTL283_OVERFLOW_EN for the optional overflow outputs.
`timescale 1ns/1ps
module tb_ttl283_adder;
  localparam int DLY = 24;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  ttl283_adder_if bus ();

  ttl283_adder #(.PROPAGATION_DELAY(DLY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic c0);
    bus.A  = a;
    bus.B  = b;
    bus.C0 = c0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    apply(4'h0, 4'h0, 1'b0);
    #3;
    chk("reset_state_q", {bus.C4_Q, bus.S_Q}, 5'b00000);
    reset = 1'b0;

    // Times of checks stay at 3 mod 10 ns, away from both clock edges.
    apply(4'h0, 4'h0, 1'b0); #50; chk("0+0+0", {bus.C4, bus.S}, 5'b00000);
    apply(4'h5, 4'h3, 1'b0); #50; chk("5+3+0", {bus.C4, bus.S}, 5'b01000);
    apply(4'h7, 4'h6, 1'b1); #50; chk("7+6+1", {bus.C4, bus.S}, 5'b01110);
    apply(4'h8, 4'h8, 1'b0); #50; chk("8+8+0", {bus.C4, bus.S}, 5'b10000);
    chk("8+8+0_q", {bus.C4_Q, bus.S_Q}, 5'b10000);
    apply(4'hF, 4'hF, 1'b0); #50; chk("F+F+0", {bus.C4, bus.S}, 5'b11110);
    apply(4'hF, 4'hF, 1'b1); #50; chk("F+F+1", {bus.C4, bus.S}, 5'b11111);
    chk("F+F+1_q", {bus.C4_Q, bus.S_Q}, 5'b11111);
    apply(4'h0, 4'h0, 1'b1); #50; chk("0+0+1", {bus.C4, bus.S}, 5'b00001);
    apply(4'h9, 4'h4, 1'b0); #50; chk("9+4+0", {bus.C4, bus.S}, 5'b01101);
    apply(4'hC, 4'h7, 1'b1); #50; chk("C+7+1", {bus.C4, bus.S}, 5'b10100);
    apply(4'hF, 4'h0, 1'b0); #50; chk("F+0+0", {bus.C4, bus.S}, 5'b01111);
    apply(4'h0, 4'hF, 1'b0); #50; chk("0+F+0", {bus.C4, bus.S}, 5'b01111);

    // Full carry ripple; S/C4 must still show the old sum just before the delay.
    apply(4'hA, 4'h5, 1'b1);
    #(DLY - 1); chk("A+5+1_early", {bus.C4, bus.S}, 5'b01111);
    #(50 - DLY + 1); chk("A+5+1", {bus.C4, bus.S}, 5'b10000);
    chk("A+5+1_q", {bus.C4_Q, bus.S_Q}, 5'b10000);

`ifdef TTL283_OVERFLOW_EN
    apply(4'h7, 4'h1, 1'b0); #50;
    chk("ovf_7+1", {4'b0000, bus.OVF}, 5'b00001);
    chk("ovf_q_7+1", {4'b0000, bus.OVF_Q}, 5'b00001);
    apply(4'h2, 4'h3, 1'b0); #50;
    chk("ovf_2+3", {4'b0000, bus.OVF}, 5'b00000);
    apply(4'hA, 4'h5, 1'b1); #50;
`endif

    // Asynchronous reset without a clock edge.
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("reset_async_q", {bus.C4_Q, bus.S_Q}, 5'b00000);
    chk("reset_keeps_comb", {bus.C4, bus.S}, 5'b10000);
`ifdef TTL283_OVERFLOW_EN
    chk("reset_ovf_q", {4'b0000, bus.OVF_Q}, 5'b00000);
`endif
    @(negedge clk);
    #1;
    chk("reset_held_q", {bus.C4_Q, bus.S_Q}, 5'b00000);
    reset = 1'b0;
    apply(4'hC, 4'h7, 1'b1);
    #2;
    chk("no_load_before_edge", {bus.C4_Q, bus.S_Q}, 5'b00000);
    @(posedge clk);
    #1;
    chk("first_load_C+7+1", {bus.C4_Q, bus.S_Q}, 5'b10100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
